psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
// - Downstream of the depthwise systolic column: consumes the 32-bit macc_out of the last bcell in a column.
// - Accumulates ACC_PASSES successive partial sums, one per kernel row, into one output pixel.
// - Buffers finished pixels in a small FIFO and presents them on a valid/ready stream to the writeback stage.
// PARAMETERS
// - OUT_DATA_WIDTH  32  width of psum_in, accumulator and out_data (signed)
// - ACC_PASSES      3   partial sums per output pixel; legal range >= 1
// - FIFO_DEPTH      4   finished-pixel FIFO entries; power of 2, >= 2
// PORTS
// - clk        in   1               clock; all logic on posedge
// - reset      in   1               synchronous, active-high
// - psum_in    in   OUT_DATA_WIDTH  signed partial sum from column bottom
// - psum_valid in   1               psum_in is valid this cycle
// - psum_ready out  1               block accepts psum_in this cycle
// - flush      in   1               discard the partially accumulated pixel
// - out_data   out  OUT_DATA_WIDTH  signed finished pixel at FIFO head
// - out_valid  out  1               out_data is valid
// - out_ready  in   1               consumer takes out_data this cycle
// - sat_flag   out  1               sticky: some accumulation saturated
// - pass_cnt   out  $clog2(ACC_PASSES+1)  partial sums accepted for current pixel
// BEHAVIOUR
// - Reset: acc=0, pass_cnt=0, FIFO empty, out_valid=0, out_data=0, sat_flag=0; psum_ready=1 from first cycle after reset.
//   Reset mid-pixel or with a non-empty FIFO drops all state.
// - Accept = psum_valid & psum_ready. psum_ready = !fifo_full & !flush (combinational).
// - FSM, 2 states:
//   - ACC: pass_cnt < ACC_PASSES-1.
//     - On accept: acc <= (pass_cnt==0) ? psum_in : sat_add(acc, psum_in); pass_cnt++.
//   - LAST: pass_cnt == ACC_PASSES-1.
//     - On accept: push post(sat_add(acc, psum_in)) into FIFO; pass_cnt <= 0; acc <= 0; return to ACC.
//   - ACC_PASSES==1: every accept pushes post(psum_in) directly.
// - sat_add: signed add at OUT_DATA_WIDTH+1 bits, clamped to [-2^(W-1), 2^(W-1)-1].
//   - Any clamp sets sat_flag; sat_flag clears only on reset.
// - Latency: pixel completed on the accept at cycle N -> out_valid=1 and out_data valid at cycle N+1.
//   - FIFO outputs are registered; no combinational path from psum_in to out_data.
// - Pop = out_valid & out_ready. Push and pop in the same cycle: occupancy unchanged, order preserved.
// - Full: psum_ready=0. A beat arriving in LAST state while full stalls, even if out_ready=1 that cycle.
//   psum_ready does not depend on out_ready.
// - Empty: out_valid=0 and out_data holds its last value. out_ready is ignored.
// - flush has priority over psum_valid:
//   - pass_cnt <= 0, acc <= 0, no push.
//   - FIFO contents, pops and sat_flag are unaffected.
// - Pointers wrap modulo FIFO_DEPTH. Occupancy counter covers 0..FIFO_DEPTH.
// CONFIGURATION
// - PSUM_DRAIN_RELU_EN defined:
//   - post(x) = (x < 0) ? 0 : x, applied at push only. Intermediate acc stays signed.
//   - sat_flag is still set by the pre-ReLU clamp.
// - PSUM_DRAIN_RELU_EN undefined: post(x) = x. Negative pixels pass through unchanged.
// TESTING
// 1. ACC_PASSES=3, psum 10, 20, -5 on consecutive cycles, out_ready=1 -> single out_data=25 one cycle after the third beat; pass_cnt 0,1,2,0.
// 2. out_ready=0, five pixels of (1,1,1) -> four out_data=3 entries; psum_ready=0 after the 12th beat; 13th beat stalls until one pop, then accepted.
// 3. psum 0x7FFFFFF0, 0x20, 0 -> out_data=0x7FFFFFFF, sat_flag=1 and still 1 after the next clean pixel.
// 4. psum 7, 7, then flush together with psum_valid -> no push, pass_cnt=0; next 1, 2, 3 -> out_data=6.
// 5. Reset asserted with 2 pixels queued and pass_cnt=2 -> next cycle out_valid=0, pass_cnt=0, sat_flag=0; then 4, 4, 4 -> out_data=12.
// 6. Pixel (-10, 2, 3): with PSUM_DRAIN_RELU_EN defined -> out_data=0; without it -> out_data=-5 (0xFFFFFFFB).

Source files
------------

// File: rtl/psum_drain_if.sv
// Column-bottom partial-sum stream in, finished-pixel stream out, plus status.
// Producer/consumer side uses master, psum_drain uses slave.
interface psum_drain_if #(
   parameter int W  = 32,
   parameter int CW = 2
) ();
   logic signed [W-1:0]  psum_in;
   logic                 psum_valid;
   logic                 psum_ready;
   logic                 flush;
   logic signed [W-1:0]  out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 sat_flag;
   logic [CW-1:0]        pass_cnt;

   modport master (
      output psum_in, psum_valid, flush, out_ready,
      input  psum_ready, out_data, out_valid, sat_flag, pass_cnt
   );

   modport slave (
      input  psum_in, psum_valid, flush, out_ready,
      output psum_ready, out_data, out_valid, sat_flag, pass_cnt
   );
endinterface

// File: rtl/psum_drain.sv
// Accumulates ACC_PASSES saturating partial sums per pixel into a small output FIFO (ReLU at push with PSUM_DRAIN_RELU_EN).
// Latency: pixel completed on accept at cycle N is visible on out_data/out_valid at N+1 (registered head).
// Backpressure: psum_ready drops while the FIFO is full or flush is high; it never looks at out_ready.
module psum_drain #(
   parameter int OUT_DATA_WIDTH = 32,
   parameter int ACC_PASSES     = 3,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   psum_drain_if.slave bus
);
   localparam int W  = OUT_DATA_WIDTH;
   localparam int CW = $clog2(ACC_PASSES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(ACC_PASSES - 1);

   typedef enum logic {S_ACC, S_LAST} state_t;
   localparam state_t INIT_STATE = (ACC_PASSES == 1) ? S_LAST : S_ACC;

   state_t               state_q;
   logic signed [W-1:0]  acc_q;
   logic [CW-1:0]        pass_cnt_q;
   logic                 sat_q;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]          count_q, count_d;
   logic [W-1:0]         mem_q [FIFO_DEPTH];
   logic [W-1:0]         out_data_q, out_data_d, head_d;
   logic                 out_valid_q, out_valid_d;

   logic signed [W-1:0]  acc_op, sum_sat, push_dat;
   logic signed [W:0]    sum_wide;
   logic                 sum_ovf, fifo_full, accept, push, pop;

   // First pass of a pixel starts from zero so acc never carries stale data.
   always_comb begin
      acc_op   = (pass_cnt_q == '0) ? '0 : acc_q;
      sum_wide = {acc_op[W-1], acc_op} + {bus.psum_in[W-1], bus.psum_in};
      sum_ovf  = sum_wide[W] ^ sum_wide[W-1];
      sum_sat  = sum_wide[W-1:0];
      if (sum_ovf) begin
         sum_sat = sum_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
      push_dat = sum_sat;
`ifdef PSUM_DRAIN_RELU_EN
      if (sum_sat[W-1]) begin
         push_dat = '0;
      end
`endif
   end

   assign fifo_full      = (count_q == (AW+1)'(FIFO_DEPTH));
   assign bus.psum_ready = !fifo_full && !bus.flush;
   assign accept         = bus.psum_valid && bus.psum_ready;
   assign push           = accept && (state_q == S_LAST);
   assign pop            = out_valid_q && bus.out_ready;

   // Next head is the incoming pixel only when nothing older remains after this cycle's pop.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (AW+1)'(1);
      end
      head_d      = (push && (wr_ptr_q == rd_ptr_d)) ? push_dat : mem_q[rd_ptr_d];
      out_valid_d = (count_d != '0);
      out_data_d  = out_valid_d ? head_d : out_data_q;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT_STATE;
         acc_q       <= '0;
         pass_cnt_q  <= '0;
         sat_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         if (accept && sum_ovf) begin
            sat_q <= 1'b1;
         end
         if (bus.flush) begin
            state_q    <= INIT_STATE;
            acc_q      <= '0;
            pass_cnt_q <= '0;
         end else if (accept) begin
            case (state_q)
               S_ACC: begin
                  acc_q      <= sum_sat;
                  pass_cnt_q <= pass_cnt_q + CW'(1);
                  if (pass_cnt_q == LAST_CNT - CW'(1)) begin
                     state_q <= S_LAST;
                  end
               end
               S_LAST: begin
                  acc_q      <= '0;
                  pass_cnt_q <= '0;
                  state_q    <= INIT_STATE;
               end
               default: state_q <= INIT_STATE;
            endcase
         end
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sat_flag  = sat_q;
   assign bus.pass_cnt  = pass_cnt_q;
endmodule

// File: tb/tb_psum_drain.sv
// Randomized bench for psum_drain: queue-based pixel model checked every cycle, plus directed scenarios.
module tb_psum_drain;
   localparam int W  = 32;
   localparam int P  = 3;
   localparam int D  = 4;
   localparam int CW = 2;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   psum_drain_if #(.W(W), .CW(CW)) bus ();

   psum_drain #(.OUT_DATA_WIDTH(W), .ACC_PASSES(P), .FIFO_DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: pixels as a queue of finished values, accumulation in wide integers.
   logic [31:0] m_q[$];
   logic [31:0] m_last = '0;
   longint      m_acc = 0;
   longint      s;
   int          m_cnt = 0;
   bit          m_sat = 1'b0;
   bit          m_rdy;

   function automatic logic [31:0] post(input longint x);
`ifdef PSUM_DRAIN_RELU_EN
      if (x < 0) return 32'd0;
`endif
      return x[31:0];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_cnt = 0; m_acc = 0; m_sat = 1'b0; m_last = '0;
      end else begin
         m_rdy = (m_q.size() < D) && !bus.flush;
         if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
         if (bus.flush) begin
            m_cnt = 0; m_acc = 0;
         end else if (bus.psum_valid && m_rdy) begin
            s = m_acc + longint'(bus.psum_in);
            if (s > MAXV) begin s = MAXV; m_sat = 1'b1; end
            else if (s < MINV) begin s = MINV; m_sat = 1'b1; end
            if (m_cnt == P-1) begin
               m_q.push_back(post(s));
               m_cnt = 0; m_acc = 0;
            end else begin
               m_acc = s; m_cnt++;
            end
         end
         if (m_q.size() > 0) m_last = m_q[0];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(bus.psum_ready), 32'((m_q.size() < D) && !bus.flush));
         chk("valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
         chk("data",  bus.out_data, m_last);
         chk("pass",  32'(bus.pass_cnt), 32'(m_cnt));
         chk("sat",   32'(bus.sat_flag), 32'(m_sat));
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d);
      int n;
      bus.psum_in = d;
      bus.psum_valid = 1'b1;
      n = 0;
      while (!bus.psum_ready && n < 200) begin
         step();
         n++;
      end
      chk("beat_ready", 32'(bus.psum_ready), 32'd1);
      step();
      bus.psum_valid = 1'b0;
   endtask

   function automatic logic [31:0] rnd_psum();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 200)) - 32'd100;
         1: return 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
         2: return 32'h8000_0000 + 32'($urandom_range(0, 65535));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bus.psum_in = '0; bus.psum_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      reset = 1'b1;
      step(); step();
      chk_en = 1'b1;
      reset = 1'b0;
      step();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data",  bus.out_data, 32'd0);
      chk("rst_ready", 32'(bus.psum_ready), 32'd1);

      // 10, 20, -5 -> 25
      bus.out_ready = 1'b1;
      chk("t1_pass0", 32'(bus.pass_cnt), 32'd0);
      beat(32'd10);  chk("t1_pass1", 32'(bus.pass_cnt), 32'd1);
      beat(32'd20);  chk("t1_pass2", 32'(bus.pass_cnt), 32'd2);
      beat(-32'sd5); chk("t1_pass3", 32'(bus.pass_cnt), 32'd0);
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_data",  bus.out_data, 32'd25);
      step();

      // Fill the FIFO with four pixels of 3, stall the 13th beat until one pop.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 12; i++) beat(32'd1);
      chk("t2_full_rdy", 32'(bus.psum_ready), 32'd0);
      chk("t2_head", bus.out_data, 32'd3);
      bus.psum_in = 32'd1; bus.psum_valid = 1'b1;
      step(); step(); step();
      chk("t2_stall_pass", 32'(bus.pass_cnt), 32'd0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("t2_pop_rdy", 32'(bus.psum_ready), 32'd1);
      step();
      bus.psum_valid = 1'b0;
      chk("t2_accept", 32'(bus.pass_cnt), 32'd1);
      beat(32'd1); beat(32'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain", bus.out_data, 32'd3);
         step();
      end
      chk("t2_empty", 32'(bus.out_valid), 32'd0);

      // Positive saturation, sticky flag.
      beat(32'h7FFF_FFF0); beat(32'h20); beat(32'd0);
      chk("t3_data", bus.out_data, 32'h7FFF_FFFF);
      chk("t3_sat",  32'(bus.sat_flag), 32'd1);
      beat(32'd1); beat(32'd1); beat(32'd1);
      chk("t3_data2", bus.out_data, 32'd3);
      chk("t3_sticky", 32'(bus.sat_flag), 32'd1);
      step();

      // Flush with a beat presented.
      beat(32'd7); beat(32'd7);
      bus.flush = 1'b1; bus.psum_in = 32'd9; bus.psum_valid = 1'b1;
      step();
      bus.flush = 1'b0; bus.psum_valid = 1'b0;
      chk("t4_pass", 32'(bus.pass_cnt), 32'd0);
      step();
      chk("t4_nopush", 32'(bus.out_valid), 32'd0);
      beat(32'd1); beat(32'd2); beat(32'd3);
      chk("t4_data", bus.out_data, 32'd6);
      step();

      // Reset with queued pixels and a half-done pixel.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) beat(32'd1);
      beat(32'd5); beat(32'd5);
      chk("t5_pre_pass", 32'(bus.pass_cnt), 32'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_pass",  32'(bus.pass_cnt), 32'd0);
      chk("t5_sat",   32'(bus.sat_flag), 32'd0);
      bus.out_ready = 1'b1;
      beat(32'd4); beat(32'd4); beat(32'd4);
      chk("t5_data", bus.out_data, 32'd12);
      step();

      // Negative pixel, with or without ReLU.
      beat(-32'sd10); beat(32'd2); beat(32'd3);
`ifdef PSUM_DRAIN_RELU_EN
      chk("t6_data", bus.out_data, 32'd0);
`else
      chk("t6_data", bus.out_data, 32'hFFFF_FFFB);
`endif
      step();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 599) == 0);
         bus.flush      = ($urandom_range(0, 23) == 0);
         bus.psum_valid = ($urandom_range(0, 3) != 0);
         bus.out_ready  = ($urandom_range(0, 2) != 0);
         bus.psum_in    = rnd_psum();
         step();
      end
      reset = 1'b0; bus.flush = 1'b0; bus.psum_valid = 1'b0; bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("final_empty", 32'(bus.out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
